// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with input synchroniser, start-glitch rejection, framing-error and break handling
// Ports: i_Clock/i_Reset (sync, active-high); i_RX_Serial async line, idle high;
//        o_RX_DV 1-cycle byte-valid pulse; o_RX_Byte last good byte; o_RX_Active frame in progress;
//        o_RX_Error 1-cycle framing-error pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_RX_Error
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, BREAK_WAIT} state_t;
    state_t      state;
    logic        sync1;
    logic        r_rx;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync1       <= 1'b1;
            r_rx        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_RX_DV     <= 1'b0;
            o_RX_Byte   <= '0;
            o_RX_Active <= 1'b0;
            o_RX_Error  <= 1'b0;
        end else begin
            sync1 <= i_RX_Serial;
            r_rx  <= sync1;
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    idx         <= '0;
                    o_RX_Active <= ~r_rx;
                    state       <= r_rx ? IDLE : START;
                end
                // Checking at HALF lands every later sample on a bit centre
                START: begin
                    if (cnt == HALF) begin
                        cnt         <= '0;
                        state       <= r_rx ? IDLE : DATA;
                        o_RX_Active <= ~r_rx;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= r_rx;
                        idx        <= idx + 3'd1;
                        state      <= (idx == 3'd7) ? STOP : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        o_RX_DV    <= r_rx;
                        o_RX_Error <= ~r_rx;
                        o_RX_Byte  <= r_rx ? shreg : o_RX_Byte;
                        state      <= r_rx ? CLEANUP : BREAK_WAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CLEANUP: begin
                    o_RX_DV     <= 1'b0;
                    o_RX_Active <= 1'b0;
                    state       <= IDLE;
                end
                // A held-low line stays here, so a break produces a single error pulse
                BREAK_WAIT: begin
                    o_RX_Error  <= 1'b0;
                    o_RX_Active <= ~r_rx;
                    state       <= r_rx ? IDLE : BREAK_WAIT;
                end
                default: begin
                    o_RX_DV     <= 1'b0;
                    o_RX_Error  <= 1'b0;
                    o_RX_Active <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 8 clocks per bit
module tb_uart_rx;
    localparam int CPB = 8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       err;
    int vectors = 0;
    int miscompares = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int late_active = 0;
    logic prev_dv = 1'b0;
    logic [7:0] got[$];
    int base;
    int dv_before;
    int err_before;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_RX_Serial(rx),
        .o_RX_DV(dv),
        .o_RX_Byte(rx_byte),
        .o_RX_Active(active),
        .o_RX_Error(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dv) begin
            dv_cnt++;
            got.push_back(rx_byte);
        end
        if (err) err_cnt++;
        if (dv && err) both_cnt++;
        if (prev_dv && active) late_active++;
        prev_dv = dv;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * CPB) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_dv", 32'(dv), 32'h0);
        chk("reset_byte", 32'(rx_byte), 32'h0);
        chk("reset_active", 32'(active), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        rst = 1'b0;
        idle(2);
        // good frame
        send_byte(8'hA5, 1'b1);
        idle(2);
        chk("a5_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("a5_byte", 32'(rx_byte), 32'hA5);
        chk("a5_err_cnt", 32'(err_cnt), 32'd0);
        chk("a5_active", 32'(active), 32'h0);
        // start glitch
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(4);
        chk("glitch_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("glitch_err_cnt", 32'(err_cnt), 32'd0);
        chk("glitch_active", 32'(active), 32'h0);
        send_byte(8'h5A, 1'b1);
        idle(2);
        chk("5a_dv_cnt", 32'(dv_cnt), 32'd2);
        chk("5a_byte", 32'(rx_byte), 32'h5A);
        // framing error
        send_byte(8'h3C, 1'b0);
        idle(2);
        chk("fe_err_cnt", 32'(err_cnt), 32'd1);
        chk("fe_dv_cnt", 32'(dv_cnt), 32'd2);
        chk("fe_byte_held", 32'(rx_byte), 32'h5A);
        chk("fe_active", 32'(active), 32'h0);
        send_byte(8'h81, 1'b1);
        idle(2);
        chk("81_byte", 32'(rx_byte), 32'h81);
        chk("81_dv_cnt", 32'(dv_cnt), 32'd3);
        // break: 40 bit times low
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        idle(2);
        chk("brk_err_cnt", 32'(err_cnt), 32'd2);
        chk("brk_dv_cnt", 32'(dv_cnt), 32'd3);
        chk("brk_active", 32'(active), 32'h0);
        send_byte(8'hFF, 1'b1);
        idle(2);
        chk("ff_byte", 32'(rx_byte), 32'hFF);
        chk("ff_dv_cnt", 32'(dv_cnt), 32'd4);
        // back-to-back, no idle gap
        base = got.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        idle(2);
        chk("b2b_dv_cnt", 32'(dv_cnt), 32'd7);
        chk("b2b_size", 32'(got.size()), 32'(base + 3));
        if (got.size() >= base + 3) begin
            chk("b2b_0", 32'(got[base]), 32'h00);
            chk("b2b_1", 32'(got[base + 1]), 32'hFF);
            chk("b2b_2", 32'(got[base + 2]), 32'h55);
        end
        // reset during bit 4 of 0x96 (bits LSB first: 0,1,1,0,1,0,0,1)
        dv_before = dv_cnt;
        err_before = err_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h96 >> i) & 8'h1 ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_dv", 32'(dv), 32'h0);
        chk("rst_byte", 32'(rx_byte), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        repeat (CPB - 5) @(negedge clk);
        chk("rst_no_dv", 32'(dv_cnt), 32'(dv_before));
        chk("rst_no_err", 32'(err_cnt), 32'(err_before));
        for (int i = 5; i < 8; i++) begin
            rx = (8'h96 >> i) & 8'h1 ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        idle(13);
        chk("rst_tail_err", 32'(err_cnt), 32'(err_before));
        send_byte(8'h96, 1'b1);
        idle(2);
        chk("96_byte", 32'(rx_byte), 32'h96);
        chk("96_last", 32'(got[got.size() - 1]), 32'h96);
        chk("dv_err_overlap", 32'(both_cnt), 32'd0);
        chk("active_after_dv", 32'(late_active), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
